// File: rtl/window_sum_pkg.sv
// window_sum_pkg: shared widths, derived pointer width and FSM state type
package window_sum_pkg;
    localparam int SAMPLE_W = 16;
    localparam int DEPTH    = 8;
    localparam int OUT_W    = 20;
    localparam int PTR_W    = $clog2(DEPTH);
    typedef enum logic {FILL, RUN} state_t;
endpackage

// File: rtl/window_sum_if.sv
// window_sum_if: sample input / window-sum output bundle between producer and window_sum
interface window_sum_if;
    import window_sum_pkg::*;
    logic                clear;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_in;
    logic [OUT_W-1:0]    data_output;
    logic                maximum_value_enable;
    logic [OUT_W-1:0]    baseline_value;
    logic                window_full;
    modport master (
        output clear, sample_valid, sample_in,
        input  data_output, maximum_value_enable, baseline_value, window_full
    );
    modport slave (
        input  clear, sample_valid, sample_in,
        output data_output, maximum_value_enable, baseline_value, window_full
    );
endinterface

// File: rtl/window_sum_sample_ring.sv
// sample_ring: DEPTH-entry sample history with wrapping write pointer and combinational read at the pointer
module sample_ring
    import window_sum_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_we,
    input  logic [SAMPLE_W-1:0] i_wdata,
    output logic [SAMPLE_W-1:0] o_rdata
);
    logic [SAMPLE_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wptr;

    assign o_rdata = r_mem[r_wptr];

    // overwrite the oldest entry and advance; pointer wraps naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst || i_clear) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr <= '0;
        end else if (i_we) begin
            r_mem[r_wptr] <= i_wdata;
            r_wptr        <= r_wptr + 1'b1;
        end
    end
endmodule

// File: rtl/window_sum.sv
// window_sum: sliding-window sum of the last DEPTH samples with full-window strobe and minimum-sum baseline
module window_sum
    import window_sum_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    window_sum_if.slave  bus
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    if (OUT_W < SAMPLE_W + PTR_W) begin : g_width_check
        $error("OUT_W too narrow for SAMPLE_W and DEPTH");
    end

    logic [SAMPLE_W-1:0] w_evict;
    logic [OUT_W-1:0]    w_sum_next;
    logic                w_accept;
    logic                w_strobe;
    state_t              w_state_next;
    state_t              r_state;
    logic [OUT_W-1:0]    r_sum;
    logic [OUT_W-1:0]    r_base;
    logic [PTR_W:0]      r_fill;
    logic                r_strobe;

    // a sample arriving with clear is dropped
    assign w_accept   = bus.sample_valid && !bus.clear;
    assign w_sum_next = r_sum + OUT_W'(bus.sample_in) - OUT_W'(w_evict);

    sample_ring u_ring (
        .clk     (clk),
        .rst     (rst),
        .i_clear (bus.clear),
        .i_we    (w_accept),
        .i_wdata (bus.sample_in),
        .o_rdata (w_evict)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FILL;
        else     r_state <= w_state_next;
    end

    // next state and strobe: the DEPTH-th sample both enters RUN and produces the first strobe
    always_comb begin
        w_state_next = r_state;
        w_strobe     = 1'b0;
        if (bus.clear) begin
            w_state_next = FILL;
        end else if (w_accept) begin
            if (r_state == RUN) begin
                w_strobe = 1'b1;
            end else if (r_fill == FULL_CNT - 1'b1) begin
                w_state_next = RUN;
                w_strobe     = 1'b1;
            end
        end
    end

    // accumulator, fill counter, strobe register and baseline minimum tracker
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.clear) begin
            r_sum    <= '0;
            r_base   <= '0;
            r_fill   <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_strobe;
            if (w_accept) begin
                r_sum  <= w_sum_next;
                r_fill <= (r_fill == FULL_CNT) ? r_fill : r_fill + 1'b1;
            end
            if (w_strobe) r_base <= (r_state == FILL || w_sum_next < r_base) ? w_sum_next : r_base;
        end
    end

    assign bus.data_output          = r_sum;
    assign bus.maximum_value_enable = r_strobe;
    assign bus.baseline_value       = r_base;
    assign bus.window_full          = (r_fill == FULL_CNT);
endmodule

// File: tb/tb_window_sum.sv
// tb_window_sum: table-driven and directed checks of window_sum sums, strobe, baseline, clear and reset
module tb_window_sum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic        c;
        logic        v;
        logic [15:0] d;
        logic [19:0] ed;
        logic        ee;
        logic [19:0] eb;
        logic        ef;
    } vec_t;
    vec_t tv[$];

    window_sum_if bus ();
    window_sum dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", n, got, exp);
        end
    endtask

    task automatic chk_all(input string n, input logic [19:0] ed, input logic ee, input logic [19:0] eb, input logic ef);
        chk({n, " data"}, 32'(bus.data_output), 32'(ed));
        chk({n, " en"},   32'(bus.maximum_value_enable), 32'(ee));
        chk({n, " base"}, 32'(bus.baseline_value), 32'(eb));
        chk({n, " full"}, 32'(bus.window_full), 32'(ef));
    endtask

    task automatic step(input logic c, input logic v, input logic [15:0] d);
        @(negedge clk);
        bus.clear        = c;
        bus.sample_valid = v;
        bus.sample_in    = d;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic c, input logic v, input int d, input int ed, input logic ee, input int eb, input logic ef);
        vec_t t;
        t.c = c; t.v = v; t.d = 16'(d); t.ed = 20'(ed); t.ee = ee; t.eb = 20'(eb); t.ef = ef;
        tv.push_back(t);
    endfunction

    initial begin
        bus.clear        = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        for (int i = 1; i <= 7; i++) add(0, 1, i, i * (i + 1) / 2, 0, 0, 0);
        add(0, 1, 8, 36, 1, 36, 1);
        add(0, 1, 9, 44, 1, 36, 1);
        add(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) add(0, 1, 10, 10 * i, 0, 0, 0);
        add(0, 1, 10, 80, 1, 80, 1);
        for (int i = 1; i <= 8; i++) add(0, 1, 0, 80 - 10 * i, 1, 80 - 10 * i, 1);
        add(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) add(0, 1, 65535, 65535 * i, 0, 0, 0);
        add(0, 1, 65535, 524280, 1, 524280, 1);
        add(0, 1, 0, 458745, 1, 458745, 1);
        add(1, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1 chk_all("reset", 0, 0, 0, 0);
        @(negedge clk) rst = 1'b0;

        foreach (tv[i]) begin
            step(tv[i].c, tv[i].v, tv[i].d);
            chk_all($sformatf("v%0d", i), tv[i].ed, tv[i].ee, tv[i].eb, tv[i].ef);
        end

        for (int i = 0; i < 8; i++) begin
            step(0, 1, 5);
            chk($sformatf("gap s%0d en", i), 32'(bus.maximum_value_enable), 32'(i == 7));
            chk($sformatf("gap s%0d data", i), 32'(bus.data_output), 32'(5 * (i + 1)));
            for (int k = 0; k < 3; k++) begin
                step(0, 0, 0);
                chk($sformatf("gap idle%0d.%0d en", i, k), 32'(bus.maximum_value_enable), 0);
                chk($sformatf("gap idle%0d.%0d data", i, k), 32'(bus.data_output), 32'(5 * (i + 1)));
            end
        end
        step(1, 0, 0);

        for (int i = 0; i < 5; i++) step(0, 1, 3);
        chk("pre-clear data", 32'(bus.data_output), 15);
        step(1, 1, 7);
        chk_all("clear+valid", 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 1);
            chk($sformatf("refill s%0d en", i), 32'(bus.maximum_value_enable), 0);
        end
        step(0, 1, 1);
        chk_all("refill s7", 8, 1, 8, 1);

        step(0, 1, 4);
        chk_all("run before rst", 11, 1, 8, 1);
        #2 rst = 1'b1;
        #1 chk_all("async rst", 0, 0, 0, 0);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 2);
            chk($sformatf("post-rst s%0d en", i), 32'(bus.maximum_value_enable), 0);
        end
        step(0, 1, 2);
        chk_all("post-rst s7", 16, 1, 16, 1);
        step(0, 0, 0);
        chk_all("post-rst idle", 16, 0, 16, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
